// File: rtl/row_max_sub.sv
// Row max-subtract: buffers a row while tracking its signed maximum, then
// replays it from the buffer emitting (x - max) through a 2-entry output FIFO.
module row_max_sub #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          len_i,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         buf_save_en,
    output logic [ADDR_WIDTH-1:0]        buf_addr_w,
    output logic signed [DATA_WIDTH-1:0] buf_data_w,
    output logic                         buf_load_en,
    output logic [ADDR_WIDTH-1:0]        buf_addr_r,
    input  logic                         buf_data_valid,
    input  logic signed [DATA_WIDTH-1:0] buf_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH:0]   out_data,
    output logic                         out_last,
    output logic signed [DATA_WIDTH-1:0] row_max,
    output logic                         busy,
    output logic                         done
);
    localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH:0]          r_len;
    logic [ADDR_WIDTH:0]          r_wcnt;
    logic [ADDR_WIDTH:0]          r_rcnt;
    logic signed [DATA_WIDTH-1:0] r_max;
    logic                         r_infl;
    logic                         r_infl_last;
    logic signed [DATA_WIDTH:0]   r_fifo_data [2];
    logic [1:0]                   r_fifo_last;
    logic                         r_wp;
    logic                         r_rp;
    logic [1:0]                   r_occ;

    logic                         w_accept;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_load;
    logic [1:0]                   w_pend;
    logic [ADDR_WIDTH:0]          w_len_sat;
    logic signed [DATA_WIDTH:0]   w_diff;

    assign w_len_sat = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    assign w_accept  = (r_state == FILL) && in_valid;
    assign w_push    = (r_state == DRAIN) && buf_data_valid;
    assign w_pop     = out_valid && out_ready;
    assign w_pend    = r_occ + {1'b0, r_infl};
    // A pop this cycle frees the slot the returning read would need, so a
    // full pending count still allows a load and keeps one output per cycle.
    assign w_load    = (r_state == DRAIN) && (r_rcnt < r_len) &&
                       ((w_pend < 2'd2) || ((w_pend == 2'd2) && w_pop));
    assign w_diff    = $signed({buf_data[DATA_WIDTH-1], buf_data}) -
                       $signed({r_max[DATA_WIDTH-1], r_max});

    assign in_ready    = (r_state == FILL);
    assign buf_save_en = w_accept;
    assign buf_addr_w  = r_wcnt[ADDR_WIDTH-1:0];
    assign buf_data_w  = in_data;
    assign buf_load_en = w_load;
    assign buf_addr_r  = r_rcnt[ADDR_WIDTH-1:0];
    assign out_valid   = (r_occ != 2'd0);
    assign out_data    = r_fifo_data[r_rp];
    assign out_last    = out_valid && r_fifo_last[r_rp];
    assign row_max     = r_max;
    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_len          <= '0;
            r_wcnt         <= '0;
            r_rcnt         <= '0;
            r_max          <= '0;
            r_infl         <= 1'b0;
            r_infl_last    <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last    <= '0;
            r_wp           <= 1'b0;
            r_rp           <= 1'b0;
            r_occ          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len_i == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_len   <= w_len_sat;
                            r_wcnt  <= '0;
                            r_rcnt  <= '0;
                            r_max   <= MOST_NEG;
                            r_state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        r_wcnt <= r_wcnt + ONE;
                        if (in_data > r_max) r_max <= in_data;
                        if (r_wcnt == r_len - ONE) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_load) r_rcnt <= r_rcnt + ONE;
                    if (w_pop && out_last) r_state <= DONE;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            // Buffer answers exactly one cycle after a load, so one flag suffices.
            r_infl      <= w_load;
            r_infl_last <= w_load && (r_rcnt == r_len - ONE);

            if (w_push) begin
                r_fifo_data[r_wp] <= w_diff;
                r_fifo_last[r_wp] <= r_infl_last;
                r_wp              <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule
